// File: rtl/note_envelope.sv
`default_nettype none
// ============================================================================
// Module      : note_envelope
// Description : ADSR amplitude envelope placed after the DDS voice. A
//               free-running divider produces the envelope tick, a five-state
//               FSM ramps a 16-bit level, and a two-stage multiply pipeline
//               scales the incoming signed sample by that level.
//
// Ports       : clk        - system clock, all logic on the rising edge
//               rst        - synchronous active-high reset
//               gate       - key held (1 = note on)
//               sample_in  - signed 16-bit sample from the DDS voice
//               atk_step   - level increment per tick in ATTACK (0 = instant)
//               dec_step   - level decrement per tick in DECAY (0 = instant)
//               sus_level  - unsigned sustain level
//               rel_step   - level decrement per tick in RELEASE (0 = instant)
//               sample_out - signed scaled sample (2-cycle latency)
//               env_level  - current unsigned envelope level
//               env_state  - IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//               active     - envelope not idle
//
// Revision    : 1.0 - initial release
// ============================================================================
module note_envelope #(
    parameter int TICK_DIV = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gate,
    input  logic [15:0] sample_in,
    input  logic [15:0] atk_step,
    input  logic [15:0] dec_step,
    input  logic [15:0] sus_level,
    input  logic [15:0] rel_step,
    output logic [15:0] sample_out,
    output logic [15:0] env_level,
    output logic [2:0]  env_state,
    output logic        active
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [15:0] C_TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [15:0] C_LEVEL_MAX = 16'hFFFF;

    logic [15:0]        r_tick_cnt;
    logic               r_gate_d;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_level;
    logic [15:0]        w_level_nxt;
    logic signed [15:0] r_s1_sample;
    logic [15:0]        r_s1_level;
    logic signed [32:0] r_prod;

    logic               w_tick;
    logic               w_rise;
    logic [16:0]        w_atk_sum;
    logic [15:0]        w_dec_diff;
    logic               w_unused_prod_bits;

    assign w_tick     = (r_tick_cnt == C_TICK_LAST);
    assign w_rise     = gate & ~r_gate_d;
    // Attack sum is kept one bit wider so the saturation test sees the carry.
    assign w_atk_sum  = {1'b0, r_level} + {1'b0, atk_step};
    // Only meaningful when r_level >= dec_step; the underflow case is
    // screened out before this value is used.
    assign w_dec_diff = r_level - dec_step;

    // ------------------------------------------------------------------
    // Next-state / next-level logic. Gate edges take priority over the
    // tick, so an edge landing on a tick cycle swallows that update.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        if (w_rise) begin
            // Retrigger keeps the current level so attack resumes smoothly.
            w_state_nxt = ST_ATTACK;
        end else if (!gate && (r_state == ST_ATTACK || r_state == ST_DECAY ||
                               r_state == ST_SUSTAIN)) begin
            w_state_nxt = ST_RELEASE;
        end else if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    w_level_nxt = 16'd0;
                end
                ST_ATTACK: begin
                    if (atk_step == 16'd0 || w_atk_sum >= {1'b0, C_LEVEL_MAX}) begin
                        w_level_nxt = C_LEVEL_MAX;
                        w_state_nxt = ST_DECAY;
                    end else begin
                        w_level_nxt = w_atk_sum[15:0];
                    end
                end
                ST_DECAY: begin
                    if (dec_step == 16'd0 || r_level < dec_step ||
                        w_dec_diff <= sus_level) begin
                        w_level_nxt = sus_level;
                        w_state_nxt = ST_SUSTAIN;
                    end else begin
                        w_level_nxt = w_dec_diff;
                    end
                end
                ST_SUSTAIN: begin
                    w_level_nxt = sus_level;
                end
                ST_RELEASE: begin
                    if (rel_step == 16'd0 || r_level <= rel_step) begin
                        w_level_nxt = 16'd0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_level_nxt = r_level - rel_step;
                    end
                end
                default: begin
                    w_level_nxt = 16'd0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Divider, envelope registers and the scaling pipeline.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt  <= 16'd0;
            r_gate_d    <= 1'b0;
            r_state     <= ST_IDLE;
            r_level     <= 16'd0;
            r_s1_sample <= 16'sd0;
            r_s1_level  <= 16'd0;
            r_prod      <= 33'sd0;
        end else begin
            r_tick_cnt  <= w_tick ? 16'd0 : r_tick_cnt + 16'd1;
            r_gate_d    <= gate;
            r_state     <= w_state_nxt;
            r_level     <= w_level_nxt;
            r_s1_sample <= $signed(sample_in);
            r_s1_level  <= r_level;
            // Level is zero-extended so it multiplies as a positive value.
            r_prod      <= r_s1_sample * $signed({1'b0, r_s1_level});
        end
    end

    // Dropping the low 16 bits is an arithmetic shift (floor); bit 32 is
    // pure sign extension and carries no information.
    assign sample_out         = r_prod[31:16];
    assign w_unused_prod_bits = ^{r_prod[32], r_prod[15:0]};

    assign env_level = r_level;
    assign env_state = r_state;
    assign active    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_note_envelope.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_envelope
// Description : Self-checking bench for note_envelope. Envelope behaviour is
//               checked against hand-derived levels; the scaling pipeline is
//               checked through a queue of expected samples that fall due two
//               clock edges after they are driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_envelope;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        gate;
    logic [15:0] sample_in;
    logic [15:0] atk_step;
    logic [15:0] dec_step;
    logic [15:0] sus_level;
    logic [15:0] rel_step;
    logic [15:0] sample_out;
    logic [15:0] env_level;
    logic [2:0]  env_state;
    logic        active;

    note_envelope #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .gate       (gate),
        .sample_in  (sample_in),
        .atk_step   (atk_step),
        .dec_step   (dec_step),
        .sus_level  (sus_level),
        .rel_step   (rel_step),
        .sample_out (sample_out),
        .env_level  (env_level),
        .env_state  (env_state),
        .active     (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] val;
    } sb_t;

    sb_t q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cnt      = 0;   // bench copy of the tick divider
    int  nstep    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h (%0d) expected=0x%0h (%0d)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [15:0] scale_ref(input logic [15:0] s, input logic [15:0] l);
        longint ps;
        longint pl;
        longint p;
        ps = longint'($signed(s));
        pl = longint'({48'd0, l});
        p  = (ps * pl) >>> 16;
        return p[15:0];
    endfunction

    // One clock edge, then settle; retire any scoreboard entries now due.
    task automatic clk_step();
        @(posedge clk);
        #1;
        if (rst) cnt = 0;
        else     cnt = (cnt + 1) % TD;
        nstep++;
        while (q.size() > 0 && q[0].due <= nstep) begin
            sb_t e;
            e = q.pop_front();
            chk("sample_out", {16'd0, sample_out}, {16'd0, e.val});
        end
    endtask

    // Advance until an edge at which the divider ticked has been consumed.
    task automatic run_to_tick();
        for (int i = 0; i < TD; i++) begin
            bit was_tick;
            was_tick = (cnt == TD - 1);
            clk_step();
            if (was_tick) return;
        end
    endtask

    // Advance until the current cycle is a tick cycle.
    task automatic to_tick_cycle();
        for (int i = 0; i < TD && cnt != TD - 1; i++) clk_step();
    endtask

    task automatic push_sample(input logic [15:0] s, input logic [15:0] lvl);
        sb_t e;
        sample_in = s;
        e.due = nstep + 2;
        e.val = scale_ref(s, lvl);
        q.push_back(e);
        clk_step();
    endtask

    task automatic chk_env(input string tag, input logic [15:0] lvl, input logic [2:0] st);
        chk({tag, "_level"}, {16'd0, env_level}, {16'd0, lvl});
        chk({tag, "_state"}, {29'd0, env_state}, {29'd0, st});
    endtask

    initial begin
        logic [15:0] dec_exp [3];
        dec_exp[0] = 16'd57343;
        dec_exp[1] = 16'd49151;
        dec_exp[2] = 16'd40959;

        rst = 1'b1; gate = 1'b0; sample_in = 16'd0;
        atk_step = 16'd16384; dec_step = 16'd8192;
        sus_level = 16'd40000; rel_step = 16'd20000;
        clk_step();
        clk_step();
        rst = 1'b0;
        chk_env("rst0", 16'd0, 3'd0);
        chk("rst0_active", {31'd0, active}, 32'd0);
        chk("rst0_out", {16'd0, sample_out}, 32'd0);

        // Mid-operation reset from ATTACK at 32768.
        sample_in = 16'h4000;
        gate = 1'b1;
        clk_step();
        run_to_tick();
        run_to_tick();
        chk_env("pre_rst", 16'd32768, 3'd1);
        rst = 1'b1; gate = 1'b0;
        clk_step();
        rst = 1'b0;
        chk_env("rst1", 16'd0, 3'd0);
        chk("rst1_active", {31'd0, active}, 32'd0);
        chk("rst1_out", {16'd0, sample_out}, 32'd0);
        clk_step();
        clk_step();
        chk("rst1_out_late", {16'd0, sample_out}, 32'd0);

        // Attack ramp.
        gate = 1'b1;
        clk_step();
        chk("atk_state", {29'd0, env_state}, 32'd1);
        chk("atk_active", {31'd0, active}, 32'd1);
        run_to_tick();
        chk_env("atk1", 16'd16384, 3'd1);
        clk_step();
        chk("atk_hold", {16'd0, env_level}, 32'd16384);
        run_to_tick();
        chk_env("atk2", 16'd32768, 3'd1);
        run_to_tick();
        chk_env("atk3", 16'd49152, 3'd1);
        run_to_tick();
        chk_env("atk4", 16'd65535, 3'd2);

        // Decay into sustain, then sustain tracking.
        for (int i = 0; i < 3; i++) begin
            run_to_tick();
            chk_env("dec", dec_exp[i], 3'd2);
        end
        run_to_tick();
        chk_env("sus", 16'd40000, 3'd3);
        sus_level = 16'd30000;
        run_to_tick();
        chk_env("sus_trk", 16'd30000, 3'd3);
        sus_level = 16'd40000;
        run_to_tick();
        chk_env("sus_back", 16'd40000, 3'd3);

        // Release to idle.
        gate = 1'b0;
        clk_step();
        chk_env("rel_enter", 16'd40000, 3'd4);
        run_to_tick();
        chk_env("rel1", 16'd20000, 3'd4);
        run_to_tick();
        chk_env("rel2", 16'd0, 3'd0);
        chk("rel2_active", {31'd0, active}, 32'd0);

        // Instantaneous steps (atk/dec/rel = 0).
        atk_step = 16'd0; dec_step = 16'd0;
        gate = 1'b1;
        clk_step();
        chk("inst_atk_state", {29'd0, env_state}, 32'd1);
        run_to_tick();
        chk_env("inst_atk", 16'd65535, 3'd2);
        run_to_tick();
        chk_env("inst_dec", 16'd40000, 3'd3);
        rel_step = 16'd0;
        gate = 1'b0;
        clk_step();
        chk("inst_rel_state", {29'd0, env_state}, 32'd4);
        run_to_tick();
        chk_env("inst_rel", 16'd0, 3'd0);

        // Retrigger during release, with the edge landing on a tick.
        gate = 1'b1;
        clk_step();
        run_to_tick();
        run_to_tick();
        chk_env("retrig_sus", 16'd40000, 3'd3);
        atk_step = 16'd16384; rel_step = 16'd20000;
        gate = 1'b0;
        clk_step();
        run_to_tick();
        chk_env("retrig_rel", 16'd20000, 3'd4);
        to_tick_cycle();
        gate = 1'b1;
        clk_step();
        chk_env("retrig_edge", 16'd20000, 3'd1);
        run_to_tick();
        chk_env("retrig_atk", 16'd36384, 3'd1);

        // Scaling at level 0 (idle).
        rel_step = 16'd0;
        gate = 1'b0;
        clk_step();
        run_to_tick();
        chk_env("scl0", 16'd0, 3'd0);
        push_sample(16'h8000, 16'd0);
        push_sample(16'h1234, 16'd0);
        push_sample(16'hFFFF, 16'd0);
        clk_step();
        clk_step();

        // Scaling at level 65535.
        atk_step = 16'd0; dec_step = 16'd0; sus_level = 16'hFFFF;
        gate = 1'b1;
        clk_step();
        run_to_tick();
        run_to_tick();
        chk_env("sclmax", 16'hFFFF, 3'd3);
        push_sample(16'h7FFF, 16'hFFFF);
        push_sample(16'h8000, 16'hFFFF);
        for (int i = 0; i < 6; i++) push_sample(16'($urandom), 16'hFFFF);
        clk_step();
        clk_step();

        // Scaling at level 32768, back-to-back.
        sus_level = 16'd32768;
        run_to_tick();
        chk_env("sclhalf", 16'd32768, 3'd3);
        push_sample(16'h4000, 16'd32768);
        push_sample(16'hC001, 16'd32768);
        for (int i = 0; i < 6; i++) push_sample(16'($urandom), 16'd32768);
        clk_step();
        clk_step();

        chk("sb_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
